// File: rtl/reg_writeback_queue_if.sv
// rtl/reg_writeback_queue_if.sv - result, write-port and hazard-lookup bundle for reg_writeback_queue
interface reg_writeback_queue_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              res_valid;
  logic              res_ready;
  logic [ADDR_W-1:0] res_addr;
  logic [DATA_W-1:0] res_data;
  logic              stall;
  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;
  logic [ADDR_W-1:0] ra;
  logic [ADDR_W-1:0] rb;
  logic              hit_a;
  logic              hit_b;
  logic [DATA_W-1:0] fwd_a;
  logic [DATA_W-1:0] fwd_b;
  logic [CNT_W-1:0]  count;

  modport slave (
    input  res_valid, res_addr, res_data, stall, ra, rb,
    output res_ready, we, wa, wd, hit_a, hit_b, fwd_a, fwd_b, count
  );

  modport master (
    output res_valid, res_addr, res_data, stall, ra, rb,
    input  res_ready, we, wa, wd, hit_a, hit_b, fwd_a, fwd_b, count
  );
endinterface

// File: rtl/reg_writeback_queue.sv
// rtl/reg_writeback_queue.sv - in-order register write-back FIFO with pending-write lookup; WB_FORWARD_EN adds data forwarding
module reg_writeback_queue #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 4
) (
  input logic                  clk,
  input logic                  rst,
  reg_writeback_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] q_addr [DEPTH];
  logic [DATA_W-1:0] q_data [DEPTH];

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count_r;
  logic              we_r;
  logic [ADDR_W-1:0] wa_r;
  logic [DATA_W-1:0] wd_r;

  logic              res_ready_c;
  logic              push;
  logic              pop;
  logic              hit_a_c;
  logic              hit_b_c;
  logic [DATA_W-1:0] fwd_a_c;
  logic [DATA_W-1:0] fwd_b_c;

  // Ready comes from registered count only, so no path from res_valid.
  assign res_ready_c = (count_r < CNT_W'(DEPTH));
  assign push        = bus.res_valid && res_ready_c;
  assign pop         = !bus.stall && (count_r != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr] <= bus.res_addr;
      q_data[wr_ptr] <= bus.res_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_r <= '0;
      we_r    <= 1'b0;
      wa_r    <= '0;
      wd_r    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        wa_r   <= q_addr[rd_ptr];
        wd_r   <= q_data[rd_ptr];
      end
      we_r <= pop;
      case ({push, pop})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Entries are walked by age from the read pointer; only the first count_r are live.
  always_comb begin
    hit_a_c = we_r && (wa_r == bus.ra);
    hit_b_c = we_r && (wa_r == bus.rb);
    for (int k = 0; k < DEPTH; k++) begin
      if (CNT_W'(k) < count_r) begin
        if (q_addr[rd_ptr + PTR_W'(k)] == bus.ra) hit_a_c = 1'b1;
        if (q_addr[rd_ptr + PTR_W'(k)] == bus.rb) hit_b_c = 1'b1;
      end
    end
  end

`ifdef WB_FORWARD_EN
  // Output stage is oldest, then queue oldest->newest; later matches override earlier ones.
  always_comb begin
    fwd_a_c = (we_r && (wa_r == bus.ra)) ? wd_r : '0;
    fwd_b_c = (we_r && (wa_r == bus.rb)) ? wd_r : '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (CNT_W'(k) < count_r) begin
        if (q_addr[rd_ptr + PTR_W'(k)] == bus.ra) fwd_a_c = q_data[rd_ptr + PTR_W'(k)];
        if (q_addr[rd_ptr + PTR_W'(k)] == bus.rb) fwd_b_c = q_data[rd_ptr + PTR_W'(k)];
      end
    end
  end
`else
  assign fwd_a_c = '0;
  assign fwd_b_c = '0;
`endif

  assign bus.res_ready = res_ready_c;
  assign bus.we        = we_r;
  assign bus.wa        = wa_r;
  assign bus.wd        = wd_r;
  assign bus.hit_a     = hit_a_c;
  assign bus.hit_b     = hit_b_c;
  assign bus.fwd_a     = fwd_a_c;
  assign bus.fwd_b     = fwd_b_c;
  assign bus.count     = count_r;
endmodule

// File: tb/tb_reg_writeback_queue.sv
// tb/tb_reg_writeback_queue.sv - scoreboard bench for reg_writeback_queue (honours WB_FORWARD_EN)
module tb_reg_writeback_queue;
`ifdef WB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   pushed;
  int   retired;
  logic [18:0] sb[$];

  reg_writeback_queue_if #(.DATA_W(16), .ADDR_W(3), .DEPTH(4)) bus ();

  reg_writeback_queue #(.DATA_W(16), .ADDR_W(3), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Holds the result on the bus until accepted; entry is scored at the accepting edge.
  task automatic send(input logic [2:0] a, input logic [15:0] d);
    bit done;
    done = 1'b0;
    bus.res_valid = 1'b1;
    bus.res_addr  = a;
    bus.res_data  = d;
    for (int n = 0; n < 50 && !done; n++) begin
      if (bus.res_ready) begin
        sb.push_back({a, d});
        pushed++;
        done = 1'b1;
      end
      cycle();
    end
    if (!done) chk("send_timeout", 32'd1, 32'd0);
  endtask

  always @(negedge clk) begin
    logic [18:0] e;
    if (!rst && bus.we) begin
      retired++;
      if (sb.size() == 0) begin
        chk("we_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("wa", 32'(bus.wa), 32'(e[18:16]));
        chk("wd", 32'(bus.wd), 32'(e[15:0]));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    errors = 0; checks = 0; pushed = 0; retired = 0;
    rst = 1'b1;
    bus.res_valid = 1'b0; bus.res_addr = '0; bus.res_data = '0;
    bus.stall = 1'b0; bus.ra = 3'd0; bus.rb = 3'd0;
    cycle(); cycle();
    rst = 1'b0;
    cycle();

    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_we", 32'(bus.we), 32'd0);
    chk("rst_ready", 32'(bus.res_ready), 32'd1);
    chk("rst_hit_a", 32'(bus.hit_a), 32'd0);
    chk("rst_fwd_a", 32'(bus.fwd_a), 32'd0);

    // single result
    send(3'd3, 16'hBEEF);
    bus.res_valid = 1'b0;
    chk("t1_count_k", 32'(bus.count), 32'd1);
    chk("t1_we_k", 32'(bus.we), 32'd0);
    cycle();
    chk("t1_we_k1", 32'(bus.we), 32'd1);
    chk("t1_count_k1", 32'(bus.count), 32'd0);
    cycle();
    chk("t1_we_k2", 32'(bus.we), 32'd0);

    // fill under stall, fifth held
    bus.stall = 1'b1;
    for (int i = 1; i <= 4; i++) send(3'(i), 16'(i * 16'h0101));
    chk("t2_count_full", 32'(bus.count), 32'd4);
    chk("t2_ready_full", 32'(bus.res_ready), 32'd0);
    bus.res_valid = 1'b1; bus.res_addr = 3'd6; bus.res_data = 16'h0606;
    cycle(); cycle();
    chk("t2_count_held", 32'(bus.count), 32'd4);
    chk("t2_we_stalled", 32'(bus.we), 32'd0);
    bus.stall = 1'b0;
    send(3'd6, 16'h0606);
    bus.res_valid = 1'b0;
    chk("t2_count_after5", 32'(bus.count), 32'd3);
    for (int i = 0; i < 6; i++) cycle();
    chk("t2_drained", 32'(bus.count), 32'd0);

    // hazard on same address
    bus.stall = 1'b1;
    send(3'd5, 16'h1111);
    send(3'd5, 16'h2222);
    bus.res_valid = 1'b0;
    bus.ra = 3'd5; bus.rb = 3'd6;
    #1;
    chk("t3_hit_a", 32'(bus.hit_a), 32'd1);
    chk("t3_hit_b", 32'(bus.hit_b), 32'd0);
    chk("t3_fwd_a", 32'(bus.fwd_a), FWD ? 32'h2222 : 32'd0);
    chk("t3_fwd_b", 32'(bus.fwd_b), 32'd0);
    bus.stall = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    chk("t3_drained", 32'(bus.count), 32'd0);

    // output-stage hit
    bus.ra = 3'd7; bus.rb = 3'd0;
    send(3'd7, 16'h7777);
    bus.res_valid = 1'b0;
    cycle();
    chk("t6_we", 32'(bus.we), 32'd1);
    chk("t6_hit_a_out", 32'(bus.hit_a), 32'd1);
    chk("t6_fwd_a_out", 32'(bus.fwd_a), FWD ? 32'h7777 : 32'd0);
    cycle();
    chk("t6_hit_a_gone", 32'(bus.hit_a), 32'd0);
    chk("t6_fwd_a_gone", 32'(bus.fwd_a), 32'd0);

    // concurrent push and pop across pointer wrap
    bus.stall = 1'b1;
    send(3'd1, 16'hA000);
    send(3'd2, 16'hA001);
    bus.stall = 1'b0;
    for (int i = 0; i < 10; i++) begin
      send(3'(i), 16'hC000 + 16'(i));
      chk("t4_count", 32'(bus.count), 32'd2);
    end
    bus.res_valid = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    chk("t4_drained", 32'(bus.count), 32'd0);

    // async reset mid-stream
    bus.stall = 1'b1;
    send(3'd1, 16'hD001);
    send(3'd2, 16'hD002);
    send(3'd3, 16'hD003);
    bus.stall = 1'b0;
    send(3'd4, 16'hD004);
    bus.res_valid = 1'b0;
    bus.ra = 3'd4;
    chk("t5_pre_count", 32'(bus.count), 32'd3);
    chk("t5_pre_we", 32'(bus.we), 32'd1);
    #2;
    rst = 1'b1;
    pushed = pushed - sb.size() - 1;
    retired = retired - 1;
    sb.delete();
    #1;
    chk("t5_rst_we", 32'(bus.we), 32'd0);
    chk("t5_rst_count", 32'(bus.count), 32'd0);
    chk("t5_rst_hit_a", 32'(bus.hit_a), 32'd0);
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("t5_no_we", 32'(bus.we), 32'd0);
    end

    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("retired_total", 32'(retired), 32'(pushed));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
